// File: rtl/nabp_pkg.sv
// Shared types and constants for the NABP angle sequencer and its shifter-side models.
package nabp_pkg;

  localparam int unsigned ANGLE_LEN_DEF = 9;
  localparam int unsigned ANGLE_SWAP_LO = 45;
  localparam int unsigned ANGLE_SWAP_HI = 135;
  localparam int unsigned ANGLE_NEG_LO  = 90;
  localparam int unsigned ANGLE_NEG_HI  = 180;

  typedef logic [ANGLE_LEN_DEF-1:0] angle_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOOKUP  = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_OFFER   = 3'd3,
    ST_RUN     = 3'd4,
    ST_NEXT    = 3'd5,
    ST_DONE    = 3'd6
  } nabp_state_e;

  function automatic logic in_range(input int unsigned a, input int unsigned lo,
                                    input int unsigned hi);
    return (a >= lo) && (a < hi);
  endfunction

endpackage

// File: rtl/nabp_angle_sequencer_if.sv
// Configuration handshake and line-completion channel between the angle sequencer and the shifter.
interface nabp_angle_sequencer_if #(
  parameter int ANGLE_LEN = 9,
  parameter int ACCU_W    = 16
);

  logic [ANGLE_LEN-1:0] sh_angle;
  logic [ACCU_W-1:0]    sh_accu_base;
  logic                 sh_swap;
  logic                 sh_neg;
  logic                 sh_cfg_valid;
  logic                 sh_cfg_ready;
  logic                 sh_line_done;

  modport master (
    output sh_angle, sh_accu_base, sh_swap, sh_neg, sh_cfg_valid,
    input  sh_cfg_ready, sh_line_done
  );

  modport slave (
    input  sh_angle, sh_accu_base, sh_swap, sh_neg, sh_cfg_valid,
    output sh_cfg_ready, sh_line_done
  );

endinterface

// File: rtl/nabp_octant_decode.sv
// Combinational octant decode: swap axes in the cot region, negative slope in the upper half-turn.
module nabp_octant_decode
  import nabp_pkg::*;
#(
  parameter int ANGLE_LEN = 9
) (
  input  logic [ANGLE_LEN-1:0] angle_i,
  output logic                 swap_o,
  output logic                 neg_o
);

  // Region membership of the current angle.
  always_comb begin
    swap_o = in_range(32'(angle_i), ANGLE_SWAP_LO, ANGLE_SWAP_HI);
    neg_o  = in_range(32'(angle_i), ANGLE_NEG_LO, ANGLE_NEG_HI);
  end

endmodule

// File: rtl/nabp_angle_sequencer.sv
// Steps the projection angle, fetches tan/cot base from the LUT and hands one config per angle to the shifter.
// Optional abort input / aborted output enabled by defining NABP_SEQ_ABORT_EN.
module nabp_angle_sequencer
  import nabp_pkg::*;
#(
  parameter int ANGLE_LEN  = 9,
  parameter int ANGLE_STEP = 1,
  parameter int ANGLE_END  = 180,
  parameter int ACCU_W     = 16,
  parameter int LINE_CNT_W = 10,
  parameter int NUM_LINES  = 256
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
`ifdef NABP_SEQ_ABORT_EN
  input  logic                  abort,
  output logic                  aborted,
`endif
  output logic                  busy,
  output logic                  done,
  output logic [ANGLE_LEN-1:0]  lut_angle,
  input  logic [ACCU_W-1:0]     lut_accu_base,
  output logic [ANGLE_LEN-1:0]  angle_idx,
  nabp_angle_sequencer_if.master sh
);

  localparam logic [2:0] S_IDLE    = ST_IDLE;
  localparam logic [2:0] S_LOOKUP  = ST_LOOKUP;
  localparam logic [2:0] S_CAPTURE = ST_CAPTURE;
  localparam logic [2:0] S_OFFER   = ST_OFFER;
  localparam logic [2:0] S_RUN     = ST_RUN;
  localparam logic [2:0] S_NEXT    = ST_NEXT;
  localparam logic [2:0] S_DONE    = ST_DONE;

  localparam logic [ANGLE_LEN:0]    STEP_W    = (ANGLE_LEN+1)'(ANGLE_STEP);
  localparam logic [ANGLE_LEN:0]    END_W     = (ANGLE_LEN+1)'(ANGLE_END);
  localparam logic [LINE_CNT_W-1:0] LINE_LAST = LINE_CNT_W'(NUM_LINES - 1);

  logic [2:0]            state_q, state_d;
  logic [ANGLE_LEN-1:0]  angle_q, angle_d;
  logic [ANGLE_LEN-1:0]  lut_angle_q, lut_angle_d;
  logic [ANGLE_LEN-1:0]  sh_angle_q, sh_angle_d;
  logic [ACCU_W-1:0]     accu_q, accu_d;
  logic                  swap_q, swap_d;
  logic                  neg_q, neg_d;
  logic                  valid_q, valid_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [LINE_CNT_W-1:0] cnt_q, cnt_d;

  logic [ANGLE_LEN:0]    angle_nxt_s;
  logic                  swap_s;
  logic                  neg_s;
  logic                  abort_s;
  logic                  abort_hit_s;

`ifdef NABP_SEQ_ABORT_EN
  assign abort_s = abort;
`else
  assign abort_s = 1'b0;
`endif

  // Widened by one bit so the end-of-sweep test cannot wrap.
  assign angle_nxt_s = {1'b0, angle_q} + STEP_W;
  assign abort_hit_s = abort_s && (state_q != S_IDLE) && (state_q != S_DONE);

  nabp_octant_decode #(
    .ANGLE_LEN (ANGLE_LEN)
  ) u_octant (
    .angle_i (angle_q),
    .swap_o  (swap_s),
    .neg_o   (neg_s)
  );

  // Next-state and next-output computation for the sweep FSM.
  always_comb begin
    state_d    = state_q;
    angle_d    = angle_q;
    sh_angle_d = sh_angle_q;
    accu_d     = accu_q;
    swap_d     = swap_q;
    neg_d      = neg_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOOKUP;
          angle_d = '0;
          busy_d  = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOOKUP: begin
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        sh_angle_d = angle_q;
        accu_d     = lut_accu_base;
        swap_d     = swap_s;
        neg_d      = neg_s;
        state_d    = S_OFFER;
      end
      S_OFFER: begin
        if (sh.sh_cfg_ready) begin
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_OFFER;
        end
      end
      S_RUN: begin
        if (sh.sh_line_done) begin
          cnt_d   = cnt_q + LINE_CNT_W'(1);
          state_d = (cnt_q == LINE_LAST) ? S_NEXT : S_RUN;
        end else begin
          state_d = S_RUN;
        end
      end
      S_NEXT: begin
        angle_d = angle_nxt_s[ANGLE_LEN-1:0];
        state_d = (angle_nxt_s >= END_W) ? S_DONE : S_LOOKUP;
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase

    state_d = abort_hit_s ? S_DONE : state_d;

    // The LUT address is loaded on entry to LOOKUP so its registered result is ready in CAPTURE.
    lut_angle_d = (state_d == S_LOOKUP) ? angle_d : lut_angle_q;
    valid_d     = (state_d == S_OFFER);
    done_d      = (state_d == S_DONE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      angle_q     <= '0;
      lut_angle_q <= '0;
      sh_angle_q  <= '0;
      accu_q      <= '0;
      swap_q      <= 1'b0;
      neg_q       <= 1'b0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      angle_q     <= angle_d;
      lut_angle_q <= lut_angle_d;
      sh_angle_q  <= sh_angle_d;
      accu_q      <= accu_d;
      swap_q      <= swap_d;
      neg_q       <= neg_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cnt_q       <= cnt_d;
    end
  end

`ifdef NABP_SEQ_ABORT_EN
  logic aborted_q;

  // Abort flag rides alongside the done pulse it caused.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      aborted_q <= 1'b0;
    end else begin
      aborted_q <= abort_hit_s;
    end
  end

  assign aborted = aborted_q;
`endif

  assign busy            = busy_q;
  assign done            = done_q;
  assign lut_angle       = lut_angle_q;
  assign angle_idx       = angle_q;
  assign sh.sh_angle     = sh_angle_q;
  assign sh.sh_accu_base = accu_q;
  assign sh.sh_swap      = swap_q;
  assign sh.sh_neg       = neg_q;
  assign sh.sh_cfg_valid = valid_q;

endmodule
